// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses around the unified-memory arbiter:
//     fetch port  : if_req, if_addr, kill          -> if_rdata, if_ready, if_stall
//     data port   : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ready, dm_stall
//     memory port : mem_rdata -> mem_en, mem_we, mem_addr, mem_wdata
//   slave  : the arbiter side (consumes requests, drives the memory port)
//   master : the environment side (pipeline requesters plus the memory itself)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;
    logic              kill;
    // data requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              dm_stall;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, kill,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ready, if_stall,
        output dm_rdata, dm_ready, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, kill,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ready, if_stall,
        input  dm_rdata, dm_ready, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction fetch
//   stage (F) and the MEM stage (D). One access at a time:
//     IDLE -> ISSUE (mem_en strobe) -> [WAIT x MEM_LAT] -> DONE (ready pulse)
//   A fetch that is killed while in flight still completes on the memory side,
//   but its data is dropped and if_ready is not raised.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (fetch, data and memory ports)
//
// Parameters
//   ADDR_W, DATA_W : address / data width
//   MEM_LAT        : memory read latency (>=1), data valid MEM_LAT cycles
//                    after the mem_en cycle
//
// Configuration macro
//   MEM_ARB_RR_EN  : when defined, simultaneous requests alternate between
//                    D and F (round robin); otherwise D always wins.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                killed_q,   killed_d;
    logic                owner_q,    owner_d;     // 1 = data port, 0 = fetch
    logic                we_q,       we_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

    logic                any_req;
    logic                grant_dm;

    assign any_req = bus.dm_req | bus.if_req;

`ifdef MEM_ARB_RR_EN
    // last_q: 1 = data port granted last, 0 = fetch granted last
    logic last_q, last_d;

    // On contention the side that did not win last time gets the port.
    assign grant_dm = bus.dm_req & (~bus.if_req | ~last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && any_req) begin
            last_d = grant_dm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_dm = bus.dm_req;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        killed_d   = killed_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (any_req) begin
                    owner_d = grant_dm;
                    addr_d  = grant_dm ? bus.dm_addr  : bus.if_addr;
                    wdata_d = grant_dm ? bus.dm_wdata : '0;
                    we_d    = grant_dm & bus.dm_we;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                killed_d = killed_q | (bus.kill & ~owner_q);
                cnt_d    = CNT_W'(MEM_LAT - 1);
                state_d  = we_q ? DONE : WAIT;
            end

            WAIT: begin
                // Uses killed_d so a kill arriving in the capture cycle
                // itself also blocks the fetch data update.
                killed_d = killed_q | (bus.kill & ~owner_q);
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else if (!killed_d) begin
                        if_rdata_d = bus.mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DONE: begin
                // Requests are not looked at here; the requester drops or
                // updates its request on the edge that ends this cycle.
                killed_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            killed_q   <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            killed_q   <= killed_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registered state, so they drop to zero as
    // soon as reset is asserted.
    // -------------------------------------------------------------------------
    logic if_ready_w;
    logic dm_ready_w;

    assign if_ready_w    = (state_q == DONE) & ~owner_q & ~killed_q;
    assign dm_ready_w    = (state_q == DONE) &  owner_q;

    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_ready  = if_ready_w;
    assign bus.dm_ready  = dm_ready_w;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_ready_w;
    assign bus.dm_stall  = bus.dm_req & ~dm_ready_w;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter (default build, strict data-over-fetch).
//   A behavioural memory with MEM_LAT read latency sits on the memory port.
//   Each access pushes its expected completion cycle and read data into a
//   per-port queue; a negedge monitor pops and compares on every ready pulse.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- memory
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [LAT:1]  pv = '0;
    logic [7:0]    pa [1:LAT];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i * 16'h0107) ^ 16'h5A5A;
            ref_mem[i] = DW'(i * 16'h0107) ^ 16'h5A5A;
        end
        mem[8'h10]     = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;
        for (int k = 1; k <= LAT; k++) pa[k] = '0;
    end

    always @(posedge clk) begin
        pv[1] <= bus.mem_en & ~bus.mem_we;
        pa[1] <= bus.mem_addr[7:0];
        for (int k = 2; k <= LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    // Garbage outside the valid slot catches off-by-one capture timing.
    assign bus.mem_rdata = pv[LAT] ? mem[pa[LAT]] : 16'hDEAD;

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [DW-1:0] data;
        logic          has_data;
        int            cyc;
    } exp_t;

    exp_t          dm_q[$];
    exp_t          if_q[$];
    int            dm_done = 0;
    int            if_done = 0;
    logic [DW-1:0] last_if_exp = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dm_ready) begin
                if (dm_q.size() == 0) begin
                    chk("dm_unexpected_ready", {31'd0, bus.dm_ready}, 32'd0);
                end else begin
                    chk("dm_ready_cycle", cyc, dm_q[0].cyc);
                    if (dm_q[0].has_data) chk("dm_rdata", {16'd0, bus.dm_rdata}, {16'd0, dm_q[0].data});
                    chk("dm_stall_at_ready", {31'd0, bus.dm_stall}, 32'd0);
                    $display("dm done  cycle %0d rdata 0x%04h", cyc, bus.dm_rdata);
                    void'(dm_q.pop_front());
                end
                dm_done <= dm_done + 1;
            end
            if (bus.if_ready) begin
                if (if_q.size() == 0) begin
                    chk("if_unexpected_ready", {31'd0, bus.if_ready}, 32'd0);
                end else begin
                    chk("if_ready_cycle", cyc, if_q[0].cyc);
                    chk("if_rdata", {16'd0, bus.if_rdata}, {16'd0, if_q[0].data});
                    chk("if_stall_at_ready", {31'd0, bus.if_stall}, 32'd0);
                    $display("if done  cycle %0d rdata 0x%04h", cyc, bus.if_rdata);
                    void'(if_q.pop_front());
                end
                if_done <= if_done + 1;
            end
        end
    end

    // ------------------------------------------------------------- requester
    // One access on either port: drive in cycle T, expect ready in T+lat,
    // check the memory strobe in its expected cycle and stall while waiting.
    task automatic access(input bit is_dm, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int lat);
        int   t;
        int   issue;
        int   start;
        exp_t e;
        @(posedge clk); #1;
        if (is_dm) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wd;
            start = dm_done;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
            start = if_done;
        end
        t          = cyc;
        issue      = t + lat - (we ? 1 : LAT + 1);
        e.cyc      = t + lat;
        e.has_data = !we;
        e.data     = ref_mem[addr[7:0]];
        if (we) ref_mem[addr[7:0]] = wd;
        if (is_dm) dm_q.push_back(e);
        else begin
            if_q.push_back(e);
            last_if_exp = e.data;
        end

        for (int k = 0; k < 40 && (is_dm ? dm_done : if_done) == start; k++) begin
            @(negedge clk); #2;
            if (cyc == issue) begin
                chk(is_dm ? "dm_mem_en" : "if_mem_en", {31'd0, bus.mem_en}, 32'd1);
                chk(is_dm ? "dm_mem_addr" : "if_mem_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
                chk(is_dm ? "dm_mem_we" : "if_mem_we", {31'd0, bus.mem_we}, {31'd0, we});
                if (we) chk("dm_mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, wd});
            end
            if (cyc == issue + 1) chk("mem_en_one_cycle", {31'd0, bus.mem_en}, 32'd0);
            if ((is_dm ? dm_done : if_done) == start)
                chk(is_dm ? "dm_stall" : "if_stall",
                    {31'd0, (is_dm ? bus.dm_stall : bus.if_stall)}, 32'd1);
        end
        if ((is_dm ? dm_done : if_done) == start)
            chk(is_dm ? "dm_timeout" : "if_timeout", is_dm ? dm_done : if_done, start + 1);

        @(posedge clk); #1;
        if (is_dm) bus.dm_req = 1'b0;
        else       bus.if_req = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_en"},    {31'd0, bus.mem_en},    32'd0);
        chk({tag, "_mem_we"},    {31'd0, bus.mem_we},    32'd0);
        chk({tag, "_mem_addr"},  {16'd0, bus.mem_addr},  32'd0);
        chk({tag, "_mem_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
        chk({tag, "_if_rdata"},  {16'd0, bus.if_rdata},  32'd0);
        chk({tag, "_dm_rdata"},  {16'd0, bus.dm_rdata},  32'd0);
        chk({tag, "_if_ready"},  {31'd0, bus.if_ready},  32'd0);
        chk({tag, "_dm_ready"},  {31'd0, bus.dm_ready},  32'd0);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0; bus.kill = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        #12;
        chk_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // single load, store, read-back, fetch
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 4);
        access(1'b1, 1'b1, 16'h0020, 16'h1234, 2);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 4);
        access(1'b0, 1'b0, 16'h0021, 16'h0000, 4);

        // contention: data first, fetch waits for the next IDLE
        fork
            access(1'b1, 1'b0, 16'h0012, 16'h0000, 4);
            access(1'b0, 1'b0, 16'h0013, 16'h0000, 9);
        join

        // kill an in-flight fetch in its WAIT cycle
        begin
            int t;
            @(posedge clk); #1;
            bus.if_req = 1'b1; bus.if_addr = 16'h0030; t = cyc;
            @(posedge clk); #1;
            chk("kill_mem_en", {31'd0, bus.mem_en}, 32'd1);
            @(posedge clk); #1;
            bus.kill = 1'b1; bus.if_req = 1'b0;
            @(posedge clk); #1;
            bus.kill = 1'b0;
            @(posedge clk); #1;
            chk("kill_cycle", cyc, t + 4);
            chk("kill_no_ready", {31'd0, bus.if_ready}, 32'd0);
            chk("kill_rdata_kept", {16'd0, bus.if_rdata}, {16'd0, last_if_exp});
            $display("kill     cycle %0d if_rdata 0x%04h", cyc, bus.if_rdata);
        end
        // fresh fetch is granted in T+5 (mem_en T+6, ready T+9)
        access(1'b0, 1'b0, 16'h0031, 16'h0000, 4);

        // kill while the data port owns the memory is ignored
        fork
            access(1'b1, 1'b0, 16'h0032, 16'h0000, 4);
            begin
                repeat (3) @(posedge clk);
                #1 bus.kill = 1'b1;
                @(posedge clk); #1 bus.kill = 1'b0;
            end
        join

        // short random mix of loads, stores and fetches
        for (int i = 0; i < 12; i++) begin
            int unsigned kind = $urandom_range(0, 2);
            logic [AW-1:0] a  = AW'($urandom_range(0, 15)) + 16'h0050;
            logic [DW-1:0] d  = DW'($urandom);
            if (kind == 0)      access(1'b1, 1'b0, a, 16'h0000, 4);
            else if (kind == 1) access(1'b1, 1'b1, a, d, 2);
            else                access(1'b0, 1'b0, a, 16'h0000, 4);
        end

        // reset in the middle of a read
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0040;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        chk("midrst_dm_stall", {31'd0, bus.dm_stall}, 32'd1);
        bus.dm_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        access(1'b1, 1'b0, 16'h0040, 16'h0000, 4);

        repeat (3) @(posedge clk);
        chk("sb_dm_empty", dm_q.size(), 0);
        chk("sb_if_empty", if_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-port, fixed-latency unified memory shared by the instruction-fetch stage and the MEM stage (LW/SW) of the 16-bit pipelined processor. The block grants one requester at a time, drives the memory port and returns read data with a one-cycle ready pulse. It raises per-requester stall signals that feed the pipeline's stall/flush logic, and it honours the PC control unit's Kill by discarding in-flight fetch results.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, instruction/data word width
- MEM_LAT, 2, memory read latency in cycles (≥1): data is valid MEM_LAT cycles after the mem_en cycle
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- if_req  in  1  fetch request; held until if_ready or kill
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
- if_ready  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ready
- kill  in  1  flush from PC control (taken branch/jump/FOR); cancels pending fetch
- dm_req  in  1  data request (MemR|MemW of MEM stage); held until dm_ready
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid while dm_ready=1
- dm_ready  out  1  one-cycle data completion pulse
- dm_stall  out  1  dm_req & ~dm_ready
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is pending, grant one, latch its address, wdata and we, and record the owner (F or D); → ISSUE. With no request pending, stay in IDLE.
- Grant rule without the macro: dm_req has strict priority over if_req.
- ISSUE: mem_en=1 and mem_we=latched we. A write goes → DONE. A read goes → WAIT with cnt=MEM_LAT-1.
- WAIT: decrement cnt each cycle. When cnt=0, capture mem_rdata into the owner's rdata register; → DONE.
- DONE: pulse the owner's ready (if_ready is suppressed if the killed flag is set). Requests are ignored in DONE; → IDLE next cycle.
- Kill:
  - kill=1 while the owner is F in ISSUE or WAIT sets the killed flag. The memory access still completes, but if_ready stays 0 and if_rdata is not updated.
  - The killed flag clears on entry to IDLE.
  - kill in IDLE or DONE, or while the owner is D, has no effect.
- if_stall and dm_stall are combinational from the request inputs and the registered ready outputs.
- rdata registers hold their last value until the next capture.
- mem_addr, mem_wdata and mem_we are held from ISSUE until the next grant. mem_en and the ready outputs are 0 in every other state.

## Timing
- Request sampled high in IDLE in cycle T:
  - mem_en in T+1.
  - Read: rdata captured at the end of T+1+MEM_LAT, ready in T+MEM_LAT+2 (T+4 at default).
  - Write: ready in T+2.
- Back-to-back accesses: the next grant happens in the IDLE cycle after DONE. Minimum spacing is MEM_LAT+3 cycles for reads and 3 cycles for writes.
- The requester must update or drop its req on the edge ending the ready cycle.
- Simultaneous if_req and dm_req in IDLE: grant per the arbitration rule; the loser's stall stays high.
- Reset, including mid-access: immediately state=IDLE, cnt=0, killed=0, last-grant=F. mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready and dm_ready all =0. The in-flight access is abandoned.

## Configuration
- MEM_ARB_RR_EN defined: round-robin when both requests are pending in IDLE. The requester not granted last wins; a single pending request is always granted. The last-grant flag updates at each grant.
- MEM_ARB_RR_EN undefined: strict data-over-fetch priority; the last-grant flag is not implemented.

## Test plan
- Single load: rst_n released, dm_req=1, dm_we=0, dm_addr=0x0010 in T, memory returns 0xBEEF → mem_en in T+1, dm_ready and dm_rdata=0xBEEF in T+4, dm_stall=0 in T+4.
- Single store: dm_we=1, dm_addr=0x0020, dm_wdata=0x1234 → mem_en=mem_we=1 with those values in T+1, dm_ready in T+2.
- Contention (macro off): if_req and dm_req both held from T, both reads → dm_ready in T+4; the fetch gets mem_en in T+6 and if_ready in T+9; if_stall=1 from T through T+8.
- Contention (macro on): two consecutive rounds with both requests continuously pending → grant order D, F, D, F.
- Kill: fetch at T (MEM_LAT=2), kill=1 in T+2 → mem_en in T+1; no if_ready in T+4; if_rdata unchanged; a new if_req is granted in T+5.
- Reset mid-read: rst_n=0 during WAIT → all outputs 0 immediately; after release, a fresh load completes with the normal T+4 latency.
